// File: rtl/ikaopm_acc_multi.sv
// Sums routed per-slot operator/noise samples into NCH channel accumulators, dumping each at its own slot.
// Latency: input latched at end of slot s, summed at end of s+1; o_PO/o_CLIP update at end of D_c.
// No backpressure: free-running slot pipeline, all state advances only on edges with i_phi1_NCEN_n low.
module ikaopm_acc_multi #(
    parameter int NCH        = 2,
    parameter int IN_W       = 14,
    parameter int ACC_W      = 18,
    parameter int OUT_W      = 16,
    parameter int DUMP_SLOT  = 13,
    parameter int NOISE_SLOT = 12
) (
    input  logic                 i_EMUCLK,
    input  logic                 i_MRST_n,
    input  logic                 i_phi1_NCEN_n,
    input  logic                 i_SYNC,
    input  logic                 i_NE,
    input  logic                 i_SNDADD,
    input  logic [NCH-1:0]       i_CH_EN,
    input  logic [IN_W-1:0]      i_OPDATA,
    input  logic [IN_W-1:0]      i_NOISE,
    input  logic                 i_SAT_EN,
    input  logic                 i_CLIP_CLR,
    output logic [NCH*OUT_W-1:0] o_PO,
    output logic [NCH-1:0]       o_PO_VALID,
    output logic [NCH-1:0]       o_SO,
    output logic [NCH-1:0]       o_CLIP
);

    localparam logic [4:0] NSLOT = 5'(NOISE_SLOT);
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [4:0]                  cnt_q, cnt_d;
    logic [IN_W-1:0]             inl_q, inl_d;
    logic [NCH-1:0]              add_q, add_d;
    logic [NCH-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [NCH-1:0][OUT_W-1:0]   po_q, po_d;
    logic [NCH-1:0]              vld_q, vld_d;
    logic [NCH-1:0]              clip_q, clip_d;
    logic [NCH-1:0]              so_bits;
    logic [ACC_W-1:0]            inl_ext;

    // Channels are spread evenly around the 32-slot frame starting at DUMP_SLOT.
    function automatic logic [4:0] dump_slot(input int c);
        return 5'((DUMP_SLOT + c * (32 / NCH)) % 32);
    endfunction

    function automatic logic out_of_range(input logic [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] v;
        v = signed'(a);
        return (v > OMAX) || (v < OMIN);
    endfunction

    function automatic logic [OUT_W-1:0] convert(input logic [ACC_W-1:0] a, input logic sat);
        logic signed [ACC_W-1:0] v;
        v = signed'(a);
        if (sat && (v > OMAX)) return {1'b0, {(OUT_W-1){1'b1}}};
        if (sat && (v < OMIN)) return {1'b1, {(OUT_W-1){1'b0}}};
        return a[OUT_W-1:0];
    endfunction

    // ofs is slots elapsed since the dump; bit ofs-1 is on the line for ofs in 1..OUT_W.
    function automatic logic ser_bit(input logic [OUT_W-1:0] w, input logic [4:0] ofs);
        logic [OUT_W-1:0] sh;
        sh = w >> (ofs - 5'd1);
        return ((ofs != 5'd0) && (ofs <= 5'(OUT_W))) ? sh[0] : 1'b0;
    endfunction

    assign inl_ext = {{(ACC_W-IN_W){inl_q[IN_W-1]}}, inl_q};

    always_comb begin
        cnt_d = i_SYNC ? 5'd0 : cnt_q + 5'd1;
        inl_d = (i_NE && (cnt_q == NSLOT)) ? i_NOISE : i_OPDATA;
        add_d = {NCH{i_SNDADD}} & i_CH_EN;
    end

    always_comb begin
        acc_d  = acc_q;
        po_d   = po_q;
        vld_d  = '0;
        clip_d = clip_q & ~{NCH{i_CLIP_CLR}};
        for (int c = 0; c < NCH; c++) begin
            if (cnt_q == dump_slot(c)) begin
                // A clip detected on this edge overrides a simultaneous clear.
                po_d[c]   = convert(acc_q[c], i_SAT_EN);
                clip_d[c] = clip_d[c] | out_of_range(acc_q[c]);
                vld_d[c]  = 1'b1;
                acc_d[c]  = add_q[c] ? inl_ext : '0;
            end else if (add_q[c]) begin
                acc_d[c] = acc_q[c] + inl_ext;
            end
        end
    end

    always_comb begin
        so_bits = '0;
        for (int c = 0; c < NCH; c++) begin
            so_bits[c] = ser_bit(po_q[c], cnt_q - dump_slot(c));
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (!i_phi1_NCEN_n) begin
            if (!i_MRST_n) begin
                cnt_q  <= '0;
                inl_q  <= '0;
                add_q  <= '0;
                acc_q  <= '0;
                po_q   <= '0;
                vld_q  <= '0;
                clip_q <= '0;
            end else begin
                cnt_q  <= cnt_d;
                inl_q  <= inl_d;
                add_q  <= add_d;
                acc_q  <= acc_d;
                po_q   <= po_d;
                vld_q  <= vld_d;
                clip_q <= clip_d;
            end
        end
    end

    assign o_PO       = po_q;
    assign o_PO_VALID = vld_q;
    assign o_SO       = so_bits;
    assign o_CLIP     = clip_q;

endmodule

// File: tb/tb_ikaopm_acc_multi.sv
// Randomized + directed bench for ikaopm_acc_multi (NCH=4, ACC_W=19) against a slot-level integer model.
module tb_ikaopm_acc_multi;

    localparam int NCH   = 4;
    localparam int IN_W  = 14;
    localparam int ACC_W = 19;
    localparam int OUT_W = 16;
    localparam int DSLOT = 13;
    localparam int NSLOT = 12;

    logic                       clk;
    logic                       mrst_n, ncen_n, sync, ne, sndadd, sat_en, clr;
    logic [NCH-1:0]             ch_en;
    logic signed [IN_W-1:0]     opdata, noise;
    logic [NCH*OUT_W-1:0]       o_po;
    logic [NCH-1:0]             o_vld, o_so, o_clip;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers, sums kept unbounded and wrapped only when read.
    int              m_cnt;
    longint          m_inl;
    logic [NCH-1:0]  m_add, m_vld, m_clip;
    longint          m_sum [NCH];
    int              m_last[NCH];

    ikaopm_acc_multi #(
        .NCH(NCH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
        .DUMP_SLOT(DSLOT), .NOISE_SLOT(NSLOT)
    ) dut (
        .i_EMUCLK(clk), .i_MRST_n(mrst_n), .i_phi1_NCEN_n(ncen_n), .i_SYNC(sync),
        .i_NE(ne), .i_SNDADD(sndadd), .i_CH_EN(ch_en), .i_OPDATA(opdata),
        .i_NOISE(noise), .i_SAT_EN(sat_en), .i_CLIP_CLR(clr),
        .o_PO(o_po), .o_PO_VALID(o_vld), .o_SO(o_so), .o_CLIP(o_clip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int dslot(input int c);
        return (DSLOT + c * (32 / NCH)) % 32;
    endfunction

    function automatic longint wrap_acc(input longint s);
        longint m, r;
        m = longint'(1) << ACC_W;
        r = s % m;
        if (r < 0) r += m;
        if (r >= m / 2) r -= m;
        return r;
    endfunction

    task automatic model_edge();
        longint v, outv;
        logic   clipped;
        if (!ncen_n) begin
            if (!mrst_n) begin
                m_cnt = 0; m_inl = 0; m_add = '0; m_vld = '0; m_clip = '0;
                for (int c = 0; c < NCH; c++) begin
                    m_sum[c] = 0; m_last[c] = 0;
                end
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (m_cnt == dslot(c)) begin
                        v       = wrap_acc(m_sum[c]);
                        clipped = (v > 32767) || (v < -32768);
                        if (sat_en) outv = (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
                        else        outv = v;
                        m_last[c] = int'(outv & 64'hFFFF);
                        m_vld[c]  = 1'b1;
                        m_clip[c] = clipped ? 1'b1 : (clr ? 1'b0 : m_clip[c]);
                        m_sum[c]  = m_add[c] ? m_inl : 0;
                    end else begin
                        m_vld[c] = 1'b0;
                        if (clr) m_clip[c] = 1'b0;
                        if (m_add[c]) m_sum[c] += m_inl;
                    end
                end
                m_inl = (ne && (m_cnt == NSLOT)) ? longint'(noise) : longint'(opdata);
                m_add = {NCH{sndadd}} & ch_en;
                m_cnt = sync ? 0 : (m_cnt + 1) % 32;
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0]    exp_po;
        logic [NCH-1:0] exp_so;
        int d;
        exp_po = '0;
        exp_so = '0;
        for (int c = 0; c < NCH; c++) begin
            exp_po = exp_po | (64'(m_last[c]) << (OUT_W * c));
            d = ((m_cnt - dslot(c)) % 32 + 32) % 32;
            if (d >= 1 && d <= OUT_W) exp_so[c] = 1'((m_last[c] >> (d - 1)) & 1);
        end
        check("po", o_po, exp_po);
        check("vld", o_vld, m_vld);
        check("so", o_so, exp_so);
        check("clip", o_clip, m_clip);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        sync = 1'b0; ne = 1'b0; sndadd = 1'b0; clr = 1'b0;
        ch_en = '0; opdata = '0; noise = '0;
    endtask

    task automatic goto_slot(input int s);
        int n;
        n = 0;
        idle_inputs();
        while (m_cnt != s && n < 70) begin
            step();
            n++;
        end
        check("goto_slot", 64'(m_cnt), 64'(s));
    endtask

    // Drives 32 contributing slots starting at D_0-1, then runs to just after the ch0 dump.
    task automatic run_frame(input logic signed [IN_W-1:0] op, input logic sat,
                             input logic ne_v, input logic signed [IN_W-1:0] nz,
                             input logic clr_dump);
        goto_slot(12);
        sat_en = sat;
        for (int i = 0; i < 32; i++) begin
            sndadd = 1'b1; ch_en = 4'b0001; opdata = op; noise = nz; ne = ne_v;
            step();
        end
        idle_inputs();
        step();
        clr = clr_dump;
        step();
        clr = 1'b0;
    endtask

    initial begin
        m_cnt = 0; m_inl = 0; m_add = '0; m_vld = '0; m_clip = '0;
        for (int c = 0; c < NCH; c++) begin
            m_sum[c] = 0; m_last[c] = 0;
        end
        idle_inputs();
        sat_en = 1'b1;
        ncen_n = 1'b0;
        mrst_n = 1'b0;
        repeat (3) step();
        check("rst_po", o_po, 64'h0);
        check("rst_vld", o_vld, 4'h0);
        check("rst_clip", o_clip, 4'h0);
        check("rst_so", o_so, 4'h0);
        mrst_n = 1'b1;
        sync = 1'b1;
        step();
        sync = 1'b0;

        // Single contribution in slot 5 on channel 0.
        goto_slot(5);
        sndadd = 1'b1; ch_en = 4'b0001; opdata = 14'sh0100;
        step();
        goto_slot(14);
        check("single_po0", o_po[15:0], 16'h0100);
        check("single_po1", o_po[31:16], 16'h0000);
        check("single_vld", o_vld, 4'b0001);
        goto_slot(21);
        check("single_so_b7", o_so[0], 1'b0);
        step();
        check("single_so_b8", o_so[0], 1'b1);

        run_frame(14'sh1FFF, 1'b1, 1'b0, 14'sh0, 1'b1);
        check("sat_pos_po", o_po[15:0], 16'h7FFF);
        check("sat_pos_clip_vs_clr", o_clip[0], 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clip_clear", o_clip[0], 1'b0);

        run_frame(-14'sd8192, 1'b1, 1'b0, 14'sh0, 1'b0);
        check("sat_neg_po", o_po[15:0], 16'h8000);
        check("sat_neg_clip", o_clip[0], 1'b1);

        run_frame(14'sh1FFF, 1'b0, 1'b0, 14'sh0, 1'b0);
        check("wrap_po", o_po[15:0], 16'hFFE0);
        check("wrap_clip", o_clip[0], 1'b1);

        run_frame(14'sh0001, 1'b1, 1'b1, 14'sh0010, 1'b0);
        check("noise_po", o_po[15:0], 16'h002F);

        // Input in slot D_2-1 = 28 must land in the following dump of channel 2.
        goto_slot(28);
        sndadd = 1'b1; ch_en = 4'b0100; opdata = 14'sh0055;
        step();
        idle_inputs();
        step();
        check("bound_first_po2", o_po[47:32], 16'h0000);
        check("bound_first_vld", o_vld[2], 1'b1);
        step();
        goto_slot(30);
        check("bound_next_po2", o_po[47:32], 16'h0055);

        // Mid-frame reset discards the partial sum.
        goto_slot(0);
        for (int i = 0; i < 6; i++) begin
            sndadd = 1'b1; ch_en = 4'b0001; opdata = 14'sh0100;
            step();
        end
        idle_inputs();
        step();
        mrst_n = 1'b0;
        step();
        mrst_n = 1'b1;
        check("midrst_po", o_po, 64'h0);
        check("midrst_clip", o_clip, 4'h0);
        check("midrst_vld", o_vld, 4'h0);
        check("midrst_so", o_so, 4'h0);
        goto_slot(2);
        for (int i = 0; i < 3; i++) begin
            sndadd = 1'b1; ch_en = 4'b0001; opdata = 14'sh0003;
            step();
        end
        goto_slot(14);
        check("midrst_next_po0", o_po[15:0], 16'h0009);

        // Random traffic with clock-enable gaps, early/late sync, rare resets and clears.
        for (int i = 0; i < 3000; i++) begin
            ncen_n = ($urandom_range(0, 4) == 0);
            mrst_n = ($urandom_range(0, 299) != 0);
            sync   = (m_cnt == 31) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) == 0);
            ne     = 1'($urandom_range(0, 1));
            sndadd = ($urandom_range(0, 3) != 0);
            ch_en  = NCH'($urandom);
            opdata = IN_W'($urandom);
            noise  = IN_W'($urandom);
            sat_en = 1'($urandom_range(0, 1));
            clr    = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
